clk_div_sched: RTL and testbench

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

---
 rtl/clk_div_sched_pkg.sv | 14 +
 rtl/clk_div_sched_core.sv | 46 ++++
 rtl/clk_div_sched.sv | 180 ++++++++++++++++++
 tb/tb_clk_div_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_sched_pkg.sv
// Shared definitions for the clock-divider scheduler: FSM encoding and default sizes.
package clk_div_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int DEF_WIDE  = 32;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_PER_W = 8;

endpackage

// File: rtl/clk_div_sched_core.sv
// Half-period counter and divided-clock flop; strobes when the next toggle is a 1->0 fall.
module clk_div_sched_core
  import clk_div_sched_pkg::*;
#(
  parameter int WIDE = DEF_WIDE
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic            enable,
  input  logic            load,
  input  logic [WIDE-1:0] half_div,
  output logic            o_Clk,
  output logic            fall_stb
);

  logic [WIDE-1:0] cnt_r;
  logic            clk_r;
  logic            terminal_s;

  assign terminal_s = (cnt_r == (half_div - WIDE'(1)));
  assign fall_stb   = enable & terminal_s & clk_r;
  assign o_Clk      = clk_r;

  // Counter and output clock; both held clear whenever the block is not running
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_r <= {WIDE{1'b0}};
      clk_r <= 1'b0;
    end else if (load) begin
      cnt_r <= {WIDE{1'b0}};
      clk_r <= 1'b0;
    end else if (enable) begin
      if (terminal_s) begin
        cnt_r <= {WIDE{1'b0}};
        clk_r <= ~clk_r;
      end else begin
        cnt_r <= cnt_r + WIDE'(1);
        clk_r <= clk_r;
      end
    end else begin
      cnt_r <= {WIDE{1'b0}};
      clk_r <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Arbitrates requesters and runs a divided clock for the granted one's period count.
// Define CLK_DIV_SCHED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int WIDE  = DEF_WIDE,
  parameter int N_REQ = DEF_N_REQ,
  parameter int PER_W = DEF_PER_W
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [N_REQ-1:0]        i_Req,
  input  logic [N_REQ*WIDE-1:0]   i_Div,
  input  logic [N_REQ*PER_W-1:0]  i_Per,
  output logic [N_REQ-1:0]        o_Grant,
  output logic                    o_Clk,
  output logic                    o_Busy,
  output logic                    o_Err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_r, state_nxt_s;
  logic [N_REQ-1:0]   grant_r;
  logic [IDX_W-1:0]   ptr_r, ptr_nxt_s, start_s, sel_s;
  logic [WIDE-1:0]    half_r, div_sel_s;
  logic [PER_W-1:0]   per_r, done_r, per_sel_s;
  logic               err_r, busy_r, abort_r;
  logic               found_s, valid_s, accept_s, reject_s;
  logic               req_held_s, fall_s, last_s, abort_now_s;
  logic [2*N_REQ-1:0] rot_s;

`ifdef CLK_DIV_SCHED_PRIO_EN
  assign start_s = {IDX_W{1'b0}};
`else
  assign start_s = ptr_r;
`endif

  // Find the first requester at or after the search start, wrapping around
  always_comb begin
    int off_v;
    int sel_v;
    off_v   = 0;
    sel_v   = 0;
    found_s = 1'b0;
    rot_s   = {i_Req, i_Req} >> start_s;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        found_s = 1'b1;
        off_v   = j;
      end else begin
        found_s = found_s;
      end
    end
    sel_v = int'(start_s) + off_v;
    if (sel_v >= N_REQ) begin
      sel_v = sel_v - N_REQ;
    end else begin
      sel_v = sel_v;
    end
    sel_s = IDX_W'(sel_v);
  end

  // Pick out the selected requester's divisor and period count
  always_comb begin
    div_sel_s = {WIDE{1'b0}};
    per_sel_s = {PER_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_s == IDX_W'(k)) begin
        div_sel_s = i_Div[k*WIDE +: WIDE];
        per_sel_s = i_Per[k*PER_W +: PER_W];
      end else begin
        div_sel_s = div_sel_s;
      end
    end
  end

  assign valid_s     = (div_sel_s != {WIDE{1'b0}}) & ~div_sel_s[0];
  assign accept_s    = (state_r == ST_IDLE) & found_s & valid_s;
  assign reject_s    = (state_r == ST_IDLE) & found_s & ~valid_s;
  assign req_held_s  = |(i_Req & grant_r);
  assign abort_now_s = abort_r | ~req_held_s;
  assign last_s      = ((done_r + PER_W'(1)) == per_r);

`ifdef CLK_DIV_SCHED_PRIO_EN
  assign ptr_nxt_s = {IDX_W{1'b0}};
`else
  assign ptr_nxt_s = (sel_s == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : (sel_s + IDX_W'(1));
`endif

  // Next-state logic; only IDLE arbitrates, exits from RUN happen on a clock fall
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (fall_s && (last_s || abort_now_s)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, grant, pointer and the job parameters latched at grant time
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r <= ST_IDLE;
      grant_r <= {N_REQ{1'b0}};
      ptr_r   <= {IDX_W{1'b0}};
      half_r  <= {WIDE{1'b0}};
      per_r   <= {PER_W{1'b0}};
      done_r  <= {PER_W{1'b0}};
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      err_r   <= reject_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            ptr_r <= ptr_nxt_s;
          end
          if (accept_s) begin
            grant_r <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_s;
            half_r  <= div_sel_s >> 1;
            per_r   <= (per_sel_s == {PER_W{1'b0}}) ? PER_W'(1) : per_sel_s;
            done_r  <= {PER_W{1'b0}};
            abort_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          done_r <= {PER_W{1'b0}};
        end
        ST_RUN: begin
          if (!req_held_s) begin
            abort_r <= 1'b1;
          end
          if (fall_s) begin
            done_r <= done_r + PER_W'(1);
          end
          if (state_nxt_s == ST_IDLE) begin
            grant_r <= {N_REQ{1'b0}};
          end
        end
        default: begin
          grant_r <= {N_REQ{1'b0}};
        end
      endcase
    end
  end

  clk_div_sched_core #(
    .WIDE(WIDE)
  ) u_core (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .enable   (state_r == ST_RUN),
    .load     (state_r == ST_LOAD),
    .half_div (half_r),
    .o_Clk    (o_Clk),
    .fall_stb (fall_s)
  );

  assign o_Grant = grant_r;
  assign o_Busy  = busy_r;
  assign o_Err   = err_r;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed self-checking bench for clk_div_sched with default parameters.
module tb_clk_div_sched;

  logic         i_Clk;
  logic         i_Rst;
  logic [3:0]   i_Req;
  logic [127:0] i_Div;
  logic [31:0]  i_Per;
  logic [3:0]   o_Grant;
  logic         o_Clk;
  logic         o_Busy;
  logic         o_Err;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_sched dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Req   (i_Req),
    .i_Div   (i_Div),
    .i_Per   (i_Per),
    .o_Grant (o_Grant),
    .o_Clk   (o_Clk),
    .o_Busy  (o_Busy),
    .o_Err   (o_Err)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    i_Req = 4'b0000;
    i_Div = 128'd0;
    i_Per = 32'd0;
    step();
    step();
    i_Rst = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    i_Req = 4'b0000;
    i_Div = 128'd0;
    i_Per = 32'd0;
    #2;
    n_checks++; if (o_Grant !== 4'b0000) $display("FAIL reset_grant got %b exp 0000", o_Grant); else n_pass++;
    n_checks++; if (o_Clk !== 1'b0) $display("FAIL reset_clk got %b exp 0", o_Clk); else n_pass++;
    n_checks++; if (o_Busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", o_Busy); else n_pass++;
    n_checks++; if (o_Err !== 1'b0) $display("FAIL reset_err got %b exp 0", o_Err); else n_pass++;
    step();
    i_Rst = 1'b0;
  endtask

  // req0, Div=4, Per=3: clock pattern from RUN entry (E2) through completion (E14)
  task automatic test_single();
    logic [12:0] exp_clk;
    exp_clk = 13'b0011001100110;
    do_reset();
    i_Div[31:0] = 32'd4;
    i_Per[7:0]  = 8'd3;
    i_Req       = 4'b0001;
    step();
    n_checks++; if (o_Grant !== 4'b0001) $display("FAIL single_grant got %b exp 0001", o_Grant); else n_pass++;
    n_checks++; if (o_Busy !== 1'b1) $display("FAIL single_busy_load got %b exp 1", o_Busy); else n_pass++;
    n_checks++; if (o_Clk !== 1'b0) $display("FAIL single_clk_load got %b exp 0", o_Clk); else n_pass++;
    i_Div[31:0] = 32'd6;
    i_Per[7:0]  = 8'd1;
    for (int c = 0; c < 13; c++) begin
      step();
      n_checks++;
      if (o_Clk !== exp_clk[12-c]) $display("FAIL single_clk cyc %0d got %b exp %b", c + 2, o_Clk, exp_clk[12-c]);
      else n_pass++;
      if (c == 11) begin
        n_checks++; if (o_Grant !== 4'b0001) $display("FAIL single_grant_hold got %b exp 0001", o_Grant); else n_pass++;
      end
      if (c == 12) begin
        n_checks++; if (o_Grant !== 4'b0000) $display("FAIL single_grant_end got %b exp 0000", o_Grant); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0) $display("FAIL single_busy_end got %b exp 0", o_Busy); else n_pass++;
      end
    end
    i_Req = 4'b0000;
    step();
    n_checks++; if (o_Grant !== 4'b0000) $display("FAIL single_idle got %b exp 0000", o_Grant); else n_pass++;
  endtask

  // req0 and req2 with Div=2, Per=1: each grant lasts 3 cycles then one idle cycle
  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    i_Div[31:0]  = 32'd2;
    i_Div[95:64] = 32'd2;
    i_Per[7:0]   = 8'd1;
    i_Per[23:16] = 8'd1;
    i_Req        = 4'b0101;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (((c - 1) % 4) == 3) exp_g = 4'b0000;
`ifdef CLK_DIV_SCHED_PRIO_EN
      else exp_g = 4'b0001;
`else
      else if ((((c - 1) / 4) % 2) == 1) exp_g = 4'b0100;
      else exp_g = 4'b0001;
`endif
      n_checks++;
      if (o_Grant !== exp_g) $display("FAIL rr_grant cyc %0d got %b exp %b", c, o_Grant, exp_g);
      else n_pass++;
    end
    i_Req = 4'b0000;
    step();
  endtask

  task automatic test_invalid();
    logic seen1;
    logic seen_err;
    seen1    = 1'b0;
    seen_err = 1'b0;
    do_reset();
    i_Div[63:32]   = 32'd5;
    i_Div[127:96]  = 32'd6;
    i_Per[31:24]   = 8'd1;
    i_Req          = 4'b1010;
    step();
    n_checks++; if (o_Err !== 1'b1) $display("FAIL inv_err got %b exp 1", o_Err); else n_pass++;
    n_checks++; if (o_Grant !== 4'b0000) $display("FAIL inv_nogrant got %b exp 0000", o_Grant); else n_pass++;
    i_Req = 4'b1000;
    step();
    n_checks++; if (o_Err !== 1'b0) $display("FAIL inv_err_pulse got %b exp 0", o_Err); else n_pass++;
    n_checks++; if (o_Grant !== 4'b1000) $display("FAIL inv_grant3 got %b exp 1000", o_Grant); else n_pass++;
    for (int c = 0; c < 8; c++) begin
      step();
      if (o_Grant[1]) seen1 = 1'b1;
      if (o_Err) seen_err = 1'b1;
    end
    n_checks++; if (seen1 !== 1'b0) $display("FAIL inv_grant1 got %b exp 0", seen1); else n_pass++;
    n_checks++; if (seen_err !== 1'b0) $display("FAIL inv_err_again got %b exp 0", seen_err); else n_pass++;
    i_Req = 4'b0000;
  endtask

  // req0 Div=8, Per=10, dropped right after the first rise
  task automatic test_abort();
    int   n;
    logic stray;
    n     = 0;
    stray = 1'b0;
    do_reset();
    i_Div[31:0] = 32'd8;
    i_Per[7:0]  = 8'd10;
    i_Req       = 4'b0001;
    while (n < 20 && o_Clk !== 1'b1) begin
      step();
      n++;
    end
    n_checks++; if (n != 6) $display("FAIL abort_rise_cyc got %0d exp 6", n); else n_pass++;
    i_Req = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        n_checks++; if (o_Clk !== 1'b1) $display("FAIL abort_high cyc %0d got %b exp 1", k, o_Clk); else n_pass++;
        n_checks++; if (o_Grant !== 4'b0001) $display("FAIL abort_grant_hold cyc %0d got %b exp 0001", k, o_Grant); else n_pass++;
      end else begin
        n_checks++; if (o_Clk !== 1'b0) $display("FAIL abort_fall got %b exp 0", o_Clk); else n_pass++;
        n_checks++; if (o_Grant !== 4'b0000) $display("FAIL abort_grant_clr got %b exp 0000", o_Grant); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", o_Busy); else n_pass++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      step();
      if (o_Clk !== 1'b0 || o_Grant !== 4'b0000) stray = 1'b1;
    end
    n_checks++; if (stray !== 1'b0) $display("FAIL abort_no_toggle got %b exp 0", stray); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int n;
    n = 0;
    do_reset();
    i_Div[31:0]  = 32'd4;
    i_Div[63:32] = 32'd4;
    i_Per[7:0]   = 8'd10;
    i_Per[15:8]  = 8'd10;
    i_Req        = 4'b0011;
    while (n < 20 && o_Clk !== 1'b1) begin
      step();
      n++;
    end
    n_checks++; if (o_Clk !== 1'b1) $display("FAIL mid_rise got %b exp 1", o_Clk); else n_pass++;
    #2;
    i_Rst = 1'b1;
    #1;
    n_checks++; if (o_Clk !== 1'b0) $display("FAIL mid_clk got %b exp 0", o_Clk); else n_pass++;
    n_checks++; if (o_Grant !== 4'b0000) $display("FAIL mid_grant got %b exp 0000", o_Grant); else n_pass++;
    n_checks++; if (o_Busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", o_Busy); else n_pass++;
    n_checks++; if (o_Err !== 1'b0) $display("FAIL mid_err got %b exp 0", o_Err); else n_pass++;
    step();
    step();
    i_Rst = 1'b0;
    step();
    n_checks++; if (o_Grant !== 4'b0001) $display("FAIL mid_regrant got %b exp 0001", o_Grant); else n_pass++;
    i_Req = 4'b0000;
  endtask

  // Div=0 is rejected; Per=0 runs exactly one period
  task automatic test_boundary();
    do_reset();
    i_Div[31:0] = 32'd0;
    i_Req       = 4'b0001;
    step();
    n_checks++; if (o_Err !== 1'b1) $display("FAIL bnd_div0_err got %b exp 1", o_Err); else n_pass++;
    i_Req = 4'b0000;
    step();
    n_checks++; if (o_Err !== 1'b0) $display("FAIL bnd_err_pulse got %b exp 0", o_Err); else n_pass++;
    i_Div[31:0] = 32'd2;
    i_Per[7:0]  = 8'd0;
    i_Req       = 4'b0001;
    step();
    n_checks++; if (o_Grant !== 4'b0001) $display("FAIL bnd_grant got %b exp 0001", o_Grant); else n_pass++;
    step();
    step();
    n_checks++; if (o_Clk !== 1'b1) $display("FAIL bnd_div2_high got %b exp 1", o_Clk); else n_pass++;
    step();
    n_checks++; if (o_Grant !== 4'b0000 || o_Clk !== 1'b0) $display("FAIL bnd_per0_end got grant %b clk %b exp 0000 0", o_Grant, o_Clk); else n_pass++;
    i_Req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_invalid();
    test_abort();
    test_reset_midrun();
    test_boundary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
